// File: rtl/cbd_pkg.sv
// Shared constants and controller state type for the eta=2 CBD noise sampler.
package cbd_pkg;

  localparam int unsigned CBD_ETA             = 2;
  localparam int unsigned CBD_WORD_W          = 64;
  localparam int unsigned CBD_BEATS_PER_WORD  = 8;
  localparam int unsigned CBD_COEFFS_PER_POLY = 256;
  localparam int unsigned CBD_RAM_W           = 32;
  localparam int unsigned KYBER_Q             = 3329;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_DRAIN,
    ST_FIN
  } cbd_ctrl_state_t;

endpackage

// File: rtl/cbd_word_buf.sv
// One-entry sponge-word buffer; clear beats load, load beats consume.
module cbd_word_buf
  import cbd_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [CBD_WORD_W-1:0] load_data,
  input  logic                  consume,
  output logic                  full,
  output logic [CBD_WORD_W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full <= 1'b0;
      data <= '0;
    end else if (clr) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= load_data;
    end else if (consume) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/cbd_sampler_ctrl.sv
// Sequences one full CBD noise polynomial: fetch sponge words, start the CBD
// core per word, and stream its output beats into coefficient RAM.
module cbd_sampler_ctrl
  import cbd_pkg::*;
#(
  parameter int unsigned N_WORDS = 16,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_start,
  input  logic                  cmd_abort,
  input  logic [ADDR_W-1:0]     cmd_base_addr,
  output logic                  busy,
  output logic                  done,
  input  logic                  src_valid,
  input  logic [CBD_WORD_W-1:0] src_data,
  output logic                  src_ready,
  output logic                  cbd_start,
  output logic [CBD_WORD_W-1:0] cbd_in_data,
  input  logic                  cbd_valid,
  input  logic [CBD_RAM_W-1:0]  cbd_out_data,
  input  logic                  cbd_done,
  output logic                  ram_we,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [CBD_RAM_W-1:0]  ram_wdata
);

  localparam int unsigned FCNT_W = $clog2(N_WORDS + 1);
  localparam int unsigned WCNT_W = $clog2(CBD_BEATS_PER_WORD * N_WORDS + 1);
  localparam int unsigned BEAT_W = $clog2(CBD_BEATS_PER_WORD);

  cbd_ctrl_state_t   state;
  logic [ADDR_W-1:0] base;
  logic [FCNT_W-1:0] fetched;
  logic [FCNT_W-1:0] issued;
  logic [BEAT_W-1:0] beat;
  logic [WCNT_W-1:0] wr_cnt;

  logic buf_full;
  logic buf_load;
  logic last_beat;
  logic more_words;

  // Any abort suppresses side effects in its own cycle; the word in flight is dropped.
  assign more_words = (fetched < FCNT_W'(N_WORDS));
  assign last_beat  = (beat == BEAT_W'(CBD_BEATS_PER_WORD - 1));
  assign buf_load   = src_valid & src_ready & ~cmd_abort;

  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN) & ~cmd_abort;
  assign src_ready = (state == ST_FETCH) |
                     ((state == ST_DRAIN) & ~buf_full & more_words);
  assign cbd_start = (state == ST_ISSUE) & cbd_done & ~cmd_abort;
  assign ram_we    = (state == ST_DRAIN) & cbd_valid & ~cmd_abort;
  assign ram_addr  = ram_we ? ADDR_W'(base + ADDR_W'(wr_cnt)) : '0;
  assign ram_wdata = ram_we ? cbd_out_data : '0;

  cbd_word_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (cmd_abort),
    .load      (buf_load),
    .load_data (src_data),
    .consume   (cbd_start),
    .full      (buf_full),
    .data      (cbd_in_data)
  );

  // State and counters; abort overrides everything, including a same-cycle start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      base    <= '0;
      fetched <= '0;
      issued  <= '0;
      beat    <= '0;
      wr_cnt  <= '0;
    end else if (cmd_abort) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_start) begin
            base    <= cmd_base_addr;
            fetched <= '0;
            issued  <= '0;
            beat    <= '0;
            wr_cnt  <= '0;
            state   <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (buf_load) begin
            fetched <= fetched + FCNT_W'(1);
            state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (cbd_done) begin
            issued <= issued + FCNT_W'(1);
            beat   <= '0;
            state  <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (buf_load) fetched <= fetched + FCNT_W'(1);
          if (cbd_valid) begin
            wr_cnt <= wr_cnt + WCNT_W'(1);
            beat   <= beat + BEAT_W'(1);
            if (last_beat) begin
              // A word landing on the last beat still counts as prefetched.
              if (issued == FCNT_W'(N_WORDS)) state <= ST_FIN;
              else if (buf_full || buf_load)  state <= ST_ISSUE;
              else                            state <= ST_FETCH;
            end
          end
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cbd_sampler_ctrl.sv
// Randomized scoreboard bench for cbd_sampler_ctrl with a sponge source and CBD core stub.
module tb_cbd_sampler_ctrl;

  localparam int unsigned N_WORDS = 16;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned N_WR    = 8 * N_WORDS;

  logic              clk;
  logic              rst_n;
  logic              cmd_start;
  logic              cmd_abort;
  logic [ADDR_W-1:0] cmd_base_addr;
  logic              busy;
  logic              done;
  logic              src_valid;
  logic [63:0]       src_data;
  logic              src_ready;
  logic              cbd_start;
  logic [63:0]       cbd_in_data;
  logic              cbd_valid;
  logic [31:0]       cbd_out_data;
  logic              cbd_done;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  int          vectors = 0;
  int          miscompares = 0;
  longint      cyc = 0;
  logic [63:0] words [N_WORDS];
  int          src_gen = 0;
  int          src_mode = 0;
  wr_t         exp_wr[$];
  logic [63:0] exp_word[$];
  int          done_cnt = 0;
  int          exp_done_total = 0;
  bit          done_ok = 0;
  longint      start_cyc = 0;
  int          exp_lat = 0;

  cbd_sampler_ctrl #(.N_WORDS(N_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_start     (cmd_start),
    .cmd_abort     (cmd_abort),
    .cmd_base_addr (cmd_base_addr),
    .busy          (busy),
    .done          (done),
    .src_valid     (src_valid),
    .src_data      (src_data),
    .src_ready     (src_ready),
    .cbd_start     (cbd_start),
    .cbd_in_data   (cbd_in_data),
    .cbd_valid     (cbd_valid),
    .cbd_out_data  (cbd_out_data),
    .cbd_done      (cbd_done),
    .ram_we        (ram_we),
    .ram_addr      (ram_addr),
    .ram_wdata     (ram_wdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Sponge source: presents words in order, advancing on each accepted handshake.
  initial begin : src_proc
    int idx;
    int gen;
    idx = 0;
    gen = 0;
    src_valid = 1'b0;
    src_data = '0;
    forever begin
      @(negedge clk);
      if (src_valid && src_ready && !cmd_abort && rst_n) idx++;
      @(posedge clk);
      #1;
      if (gen != src_gen) begin
        gen = src_gen;
        idx = 0;
      end
      src_valid = (idx < int'(N_WORDS)) && (src_mode == 0 || $urandom_range(3) == 0);
      src_data  = (idx < int'(N_WORDS)) ? words[idx] : 64'h0;
    end
  end

  // CBD core stub: one load cycle, then 8 beats of word[31:0]+beat, then idle again.
  initial begin : cbd_stub
    int          phase;
    bit          start_seen;
    logic [63:0] w;
    logic [63:0] w_next;
    phase = 0;
    w = '0;
    w_next = '0;
    cbd_valid = 1'b0;
    cbd_out_data = '0;
    cbd_done = 1'b1;
    forever begin
      @(negedge clk);
      start_seen = cbd_start;
      if (cbd_start) w_next = cbd_in_data;
      @(posedge clk);
      #1;
      if (start_seen) begin
        phase = 1;
        w = w_next;
      end else if (phase != 0) begin
        phase = (phase == 9) ? 0 : phase + 1;
      end
      cbd_done     = (phase == 0);
      cbd_valid    = (phase >= 2);
      cbd_out_data = cbd_valid ? w[31:0] + 32'(phase - 2) : 32'h0;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a write, start or done.
  initial begin : monitor
    wr_t         e;
    logic [63:0] ew;
    bit          prev_done;
    prev_done = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        vectors++;
        if ({busy, done, src_ready, cbd_start, ram_we} != 5'b0 || cbd_in_data != 64'h0 ||
            ram_addr != '0 || ram_wdata != 32'h0) begin
          miscompares++;
          $display("FAIL reset_outputs: busy=%b done=%b rdy=%b start=%b we=%b in=%h addr=%h wd=%h, want all 0",
                   busy, done, src_ready, cbd_start, ram_we, cbd_in_data, ram_addr, ram_wdata);
        end
        prev_done = 0;
      end else begin
        if (prev_done) begin
          vectors++;
          if (busy) begin
            miscompares++;
            $display("FAIL busy_after_done: busy=%b want 0", busy);
          end
        end
        if (ram_we) begin
          vectors++;
          if (exp_wr.size() == 0) begin
            miscompares++;
            $display("FAIL ram_write: unexpected write addr=%h data=%h", ram_addr, ram_wdata);
          end else begin
            e = exp_wr.pop_front();
            if (ram_addr != e.addr || ram_wdata != e.data) begin
              miscompares++;
              $display("FAIL ram_write: got addr=%h data=%h want addr=%h data=%h",
                       ram_addr, ram_wdata, e.addr, e.data);
            end
          end
        end
        if (cbd_start) begin
          vectors++;
          if (exp_word.size() == 0) begin
            miscompares++;
            $display("FAIL cbd_start: unexpected start with word %h", cbd_in_data);
          end else begin
            ew = exp_word.pop_front();
            if (cbd_in_data != ew || !cbd_done || src_ready) begin
              miscompares++;
              $display("FAIL cbd_start: got word=%h cbd_done=%b src_ready=%b want word=%h cbd_done=1 src_ready=0",
                       cbd_in_data, cbd_done, src_ready, ew);
            end
          end
        end
        if (done) begin
          vectors++;
          done_cnt++;
          if (!done_ok) begin
            miscompares++;
            $display("FAIL done: unexpected done pulse at cycle %0d", cyc);
          end else if (exp_wr.size() != 0 || (exp_lat > 0 && (cyc - start_cyc) != longint'(exp_lat))) begin
            miscompares++;
            $display("FAIL done: latency %0d writes_left %0d, want latency %0d writes_left 0",
                     cyc - start_cyc, exp_wr.size(), exp_lat);
          end
        end
        prev_done = done;
      end
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: write j lands at (base+j) mod 2^ADDR_W with word[j/8][31:0]+j%8.
  task automatic start_poly(input logic [ADDR_W-1:0] base, input int mode, input int lat);
    for (int i = 0; i < int'(N_WORDS); i++) begin
      words[i] = {$urandom, $urandom};
      exp_word.push_back(words[i]);
    end
    for (int j = 0; j < int'(N_WR); j++)
      exp_wr.push_back('{addr: ADDR_W'(int'(base) + j), data: words[j / 8][31:0] + 32'(j % 8)});
    src_mode = mode;
    src_gen++;
    exp_done_total++;
    done_ok = 1;
    exp_lat = lat;
    cmd_base_addr = base;
    cmd_start = 1'b1;
    start_cyc = cyc;
    tick(1);
    cmd_start = 1'b0;
    cmd_base_addr = $urandom;
  endtask

  task automatic end_check(input string name);
    vectors++;
    if (done_cnt != exp_done_total || exp_wr.size() != 0 || exp_word.size() != 0) begin
      miscompares++;
      $display("FAIL %s: done_cnt=%0d writes_left=%0d words_left=%0d, want done_cnt=%0d and 0 left",
               name, done_cnt, exp_wr.size(), exp_word.size(), exp_done_total);
    end
    exp_wr.delete();
    exp_word.delete();
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done_cnt < exp_done_total && n < budget) begin
      tick(1);
      n++;
    end
    tick(3);
    end_check(name);
  endtask

  initial begin : main
    int n;
    rst_n = 1'b0;
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
    cmd_base_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);

    start_poly(8'h00, 0, 162);
    wait_done("poly_base00", 400);

    start_poly(8'hF0, 0, 162);
    wait_done("poly_wrap_f0", 400);

    start_poly(ADDR_W'($urandom), 1, 0);
    wait_done("poly_sparse_src", 3000);

    // Start and abort together in IDLE: abort wins.
    cmd_start = 1'b1;
    cmd_abort = 1'b1;
    tick(1);
    cmd_start = 1'b0;
    cmd_abort = 1'b0;
    vectors++;
    if (busy) begin
      miscompares++;
      $display("FAIL start_abort_idle: busy=%b want 0", busy);
    end

    // Start while busy must be ignored.
    start_poly(8'h33, 0, 162);
    tick(48);
    cmd_base_addr = 8'h99;
    cmd_start = 1'b1;
    tick(1);
    cmd_start = 1'b0;
    wait_done("start_in_drain", 400);

    // Abort right after the 4th beat of the 3rd word.
    start_poly(8'h10, 0, 0);
    n = 0;
    while (exp_wr.size() > int'(N_WR) - 20 && n < 200) begin
      tick(1);
      n++;
    end
    exp_wr.delete();
    exp_word.delete();
    exp_done_total--;
    done_ok = 0;
    cmd_abort = 1'b1;
    tick(1);
    cmd_abort = 1'b0;
    tick(1);
    end_check("abort");
    start_poly(8'h40, 0, 0);
    wait_done("restart_after_abort", 500);

    // Asynchronous reset mid-DRAIN, then stray CBD beats must not write.
    start_poly(8'h80, 0, 162);
    tick(44);
    #2;
    rst_n = 1'b0;
    exp_wr.delete();
    exp_word.delete();
    exp_done_total--;
    done_ok = 0;
    #1;
    vectors++;
    if (busy || ram_we || src_ready || cbd_start || ram_addr != '0 || ram_wdata != 32'h0) begin
      miscompares++;
      $display("FAIL async_reset: busy=%b we=%b rdy=%b start=%b addr=%h wd=%h want all 0",
               busy, ram_we, src_ready, cbd_start, ram_addr, ram_wdata);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(15);
    end_check("reset_mid_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
